bfifo_fwft_stage: RTL and testbench

Read-side adapter placed directly downstream of the BlockRAM FIFO (`BFIFO`). It drives the FIFO's `deq` and absorbs the FIFO's one-cycle registered read latency. It presents a first-word-fall-through valid/ready stream to the consumer. A 2-entry output buffer with read-in-flight tracking sustains one word per cycle under continuous `dout_ready`.

---
 rtl/bfifo_fwft_stage_pkg.sv | 16 +
 rtl/bfifo_fwft_stage_if.sv | 24 ++
 rtl/bfifo_fwft_stage.sv | 107 ++++++++++
 tb/tb_bfifo_fwft_stage.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/bfifo_fwft_stage_pkg.sv
// bfifo_fwft_stage_pkg: helper shared by the FWFT read-side adapter.
// Holds the occupancy arithmetic so the throttle rule and the occupancy
// update always come from the same expression.
package bfifo_fwft_stage_pkg;

  // Occupancy after this edge, widened to 3 bits so the throttle compare
  // cannot wrap: occ + rd_pend - pop.
  function automatic logic [2:0] occ_next(
    input logic [1:0] occ,
    input logic       rd_pend,
    input logic       pop
  );
    return {1'b0, occ} + {2'b00, rd_pend} - {2'b00, pop};
  endfunction

endpackage : bfifo_fwft_stage_pkg

// File: rtl/bfifo_fwft_stage_if.sv
// bfifo_fwft_stage_if: first-word-fall-through valid/ready stream produced
// by the adapter. The adapter side is the master; the consumer is the slave.
interface bfifo_fwft_stage_if #(
  parameter int FIFO_WIDTH = 32
);
  logic [FIFO_WIDTH-1:0] dout;
  logic                  dout_valid;
  logic                  dout_ready;
  logic [1:0]            occ;

  modport master (
    output dout,
    output dout_valid,
    output occ,
    input  dout_ready
  );

  modport slave (
    input  dout,
    input  dout_valid,
    input  occ,
    output dout_ready
  );
endinterface : bfifo_fwft_stage_if

// File: rtl/bfifo_fwft_stage.sv
// bfifo_fwft_stage: read-side adapter for the BlockRAM FIFO.
// Drives the FIFO dequeue strobe, absorbs its one-cycle registered read
// latency and presents a FWFT stream. A head entry (buf0) plus a skid entry
// (buf1) let a word already in flight land even when the consumer stalls,
// so a continuously ready consumer sees one word per cycle.
module bfifo_fwft_stage
  import bfifo_fwft_stage_pkg::*;
#(
  parameter int FIFO_WIDTH = 32
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  fifo_emp,
  input  logic [FIFO_WIDTH-1:0] fifo_dot,
  output logic                  fifo_deq,
  bfifo_fwft_stage_if.master    out_if
);

  localparam int         OCC_W     = 2;
  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_ONE   = 2'd1;
  localparam logic [1:0] OCC_FULL  = 2'd2;

  logic [OCC_W-1:0]      occ_r;
  logic                  rd_pend_r;
  logic [FIFO_WIDTH-1:0] buf0_r;
  logic [FIFO_WIDTH-1:0] buf1_r;

  logic                  valid_s;
  logic                  pop_s;
  logic [2:0]            occ_sum_s;

  // Handshake and throttle: only request a word when the buffer is sure to
  // have room for it, counting the word already in flight.
  always_comb begin
    valid_s   = 1'b0;
    pop_s     = 1'b0;
    occ_sum_s = 3'd0;
    fifo_deq  = 1'b0;
    if (occ_r != OCC_EMPTY) begin
      valid_s = 1'b1;
    end else begin
      valid_s = 1'b0;
    end
    pop_s     = valid_s & out_if.dout_ready;
    occ_sum_s = occ_next(occ_r, rd_pend_r, pop_s);
    if (!fifo_emp && (occ_sum_s < 3'd2)) begin
      fifo_deq = 1'b1;
    end else begin
      fifo_deq = 1'b0;
    end
  end

  // Occupancy and read-in-flight tracking; rd_pend marks the cycle in which
  // fifo_dot carries the word requested on the previous cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      occ_r     <= OCC_EMPTY;
      rd_pend_r <= 1'b0;
    end else begin
      occ_r     <= occ_sum_s[OCC_W-1:0];
      rd_pend_r <= fifo_deq;
    end
  end

  // Data path: land the in-flight word in the first free slot after any pop,
  // and shift the skid entry into the head whenever the head is consumed.
  always_ff @(posedge CLK) begin
    if (RST) begin
      buf0_r <= '0;
      buf1_r <= '0;
    end else if (rd_pend_r) begin
      case (occ_r)
        OCC_EMPTY: begin
          buf0_r <= fifo_dot;
        end
        OCC_ONE: begin
          if (pop_s) begin
            buf0_r <= fifo_dot;
          end else begin
            buf1_r <= fifo_dot;
          end
        end
        OCC_FULL: begin
          // Only reachable together with a pop: the throttle never lets a
          // third word be in flight while both slots are held.
          buf0_r <= buf1_r;
          buf1_r <= fifo_dot;
        end
        default: begin
          buf0_r <= buf0_r;
          buf1_r <= buf1_r;
        end
      endcase
    end else if (pop_s) begin
      buf0_r <= buf1_r;
    end else begin
      buf0_r <= buf0_r;
      buf1_r <= buf1_r;
    end
  end

  assign out_if.dout       = buf0_r;
  assign out_if.dout_valid = valid_s;
  assign out_if.occ        = occ_r;

endmodule : bfifo_fwft_stage

// File: tb/tb_bfifo_fwft_stage.sv
// tb_bfifo_fwft_stage: directed and random checks of the FWFT adapter
// against a behavioural registered-read FIFO and an in-order scoreboard.
module tb_bfifo_fwft_stage;

  logic        CLK;
  logic        RST;
  logic        fifo_emp;
  logic [31:0] fifo_dot;
  logic        fifo_deq;
  logic        enq;
  logic [31:0] enq_data;

  int checks   = 0;
  int failures = 0;
  int deq_viol = 0;
  int occ_viol = 0;
  int sb_pops  = 0;

  logic [31:0] mq[$];
  logic [31:0] exp_q[$];

  bfifo_fwft_stage_if #(.FIFO_WIDTH(32)) sif ();

  bfifo_fwft_stage #(.FIFO_WIDTH(32)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .fifo_emp (fifo_emp),
    .fifo_dot (fifo_dot),
    .fifo_deq (fifo_deq),
    .out_if   (sif)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      failures = failures + 1;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Upstream FIFO model: registered read data, empty flag updated at the edge.
  always @(posedge CLK) begin
    if (RST) begin
      mq.delete();
      fifo_dot <= 32'd0;
      fifo_emp <= 1'b1;
    end else begin
      if (fifo_deq) begin
        if (mq.size() == 0) begin
          deq_viol = deq_viol + 1;
        end else begin
          fifo_dot <= mq.pop_front();
        end
      end
      if (enq) begin
        mq.push_back(enq_data);
      end
      fifo_emp <= (mq.size() == 0);
    end
  end

  // Scoreboard and protocol monitor, sampled mid-cycle.
  always @(negedge CLK) begin
    if (!RST) begin
      if (fifo_deq && fifo_emp) deq_viol = deq_viol + 1;
      if (sif.occ > 2'd2) occ_viol = occ_viol + 1;
      if (sif.dout_valid && sif.dout_ready) begin
        sb_pops = sb_pops + 1;
        if (exp_q.size() == 0) begin
          check_eq("sb_underflow", 64'd1, 64'd0);
        end else begin
          check_eq("sb_order", {32'd0, sif.dout}, {32'd0, exp_q.pop_front()});
        end
      end
    end
  end

  // One cycle: drive inputs just after the edge, return at the falling edge.
  task automatic cyc(input logic e, input logic [31:0] d, input logic r);
    @(posedge CLK);
    #1;
    enq            = e;
    enq_data       = d;
    sif.dout_ready = r;
    if (e) exp_q.push_back(d);
    @(negedge CLK);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int          deq_cnt;
    int          pop_cnt;
    logic [31:0] popped;
    logic [31:0] ev;
    logic        got;

    RST            = 1'b1;
    enq            = 1'b0;
    enq_data       = 32'd0;
    sif.dout_ready = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b0;
    @(negedge CLK);
    check_eq("rst_occ", {62'd0, sif.occ}, 64'd0);
    check_eq("rst_valid", {63'd0, sif.dout_valid}, 64'd0);
    check_eq("rst_dout", {32'd0, sif.dout}, 64'd0);
    check_eq("rst_deq", {63'd0, fifo_deq}, 64'd0);

    // Fill then drain.
    cyc(1'b1, 32'h11, 1'b1);
    check_eq("fill_valid_c0", {63'd0, sif.dout_valid}, 64'd0);
    cyc(1'b1, 32'h22, 1'b1);
    check_eq("fill_deq_c1", {63'd0, fifo_deq}, 64'd1);
    check_eq("fill_valid_c1", {63'd0, sif.dout_valid}, 64'd0);
    cyc(1'b1, 32'h33, 1'b1);
    check_eq("fill_valid_c2", {63'd0, sif.dout_valid}, 64'd0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 32'd0, 1'b1);
      ev = 32'h11 * 32'(i + 1);
      check_eq("fill_out", {31'd0, sif.dout_valid, sif.dout}, {31'd0, 1'b1, ev});
    end
    cyc(1'b0, 32'd0, 1'b1);
    check_eq("fill_occ_end", {62'd0, sif.occ}, 64'd0);
    check_eq("fill_valid_end", {63'd0, sif.dout_valid}, 64'd0);

    // Stall: consumer not ready while eight words arrive.
    deq_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(i < 8, 32'hA0 + 32'(i), 1'b0);
      if (fifo_deq) deq_cnt = deq_cnt + 1;
    end
    check_eq("stall_deq_pulses", 64'(deq_cnt), 64'd2);
    check_eq("stall_occ", {62'd0, sif.occ}, 64'd2);
    check_eq("stall_head", {31'd0, sif.dout_valid, sif.dout}, {31'd0, 1'b1, 32'hA0});
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 32'd0, 1'b1);
      ev = 32'hA0 + 32'(i);
      check_eq("stall_release", {31'd0, sif.dout_valid, sif.dout}, {31'd0, 1'b1, ev});
    end
    cyc(1'b0, 32'd0, 1'b1);
    check_eq("stall_occ_end", {62'd0, sif.occ}, 64'd0);

    // Streaming: one word per cycle after the fill.
    for (int i = 0; i < 1003; i++) begin
      cyc(1'b1, 32'h1000_0000 + 32'(i), 1'b1);
      if (i >= 3) begin
        ev = 32'h1000_0000 + 32'(i - 3);
        check_eq("stream", {31'd0, sif.dout_valid, sif.dout}, {31'd0, 1'b1, ev});
      end
    end
    repeat (6) cyc(1'b0, 32'd0, 1'b1);
    check_eq("stream_drained", 64'(exp_q.size()), 64'd0);
    check_eq("stream_occ_end", {62'd0, sif.occ}, 64'd0);

    // Random enqueue and random backpressure.
    for (int i = 0; i < 400; i++) begin
      cyc(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < 300; i++) begin
      if (exp_q.size() == 0) break;
      cyc(1'b0, 32'd0, 1'b1);
    end
    check_eq("rand_drained", 64'(exp_q.size()), 64'd0);
    repeat (2) cyc(1'b0, 32'd0, 1'b1);

    // Single word with toggling ready.
    cyc(1'b1, 32'h5A, 1'b0);
    pop_cnt = 0;
    popped  = 32'd0;
    for (int i = 0; i < 12; i++) begin
      cyc(1'b0, 32'd0, (i % 2) == 1);
      if (sif.dout_valid && sif.dout_ready) begin
        pop_cnt = pop_cnt + 1;
        popped  = sif.dout;
      end
    end
    check_eq("single_pop_count", 64'(pop_cnt), 64'd1);
    check_eq("single_pop_data", {32'd0, popped}, 64'h5A);
    check_eq("single_valid_end", {63'd0, sif.dout_valid}, 64'd0);
    check_eq("single_deq_end", {63'd0, fifo_deq}, 64'd0);
    check_eq("single_emp_end", {63'd0, fifo_emp}, 64'd1);

    // Reset while a word is buffered and another is in flight.
    cyc(1'b1, 32'hB0, 1'b0);
    cyc(1'b1, 32'hB1, 1'b0);
    cyc(1'b1, 32'hB2, 1'b0);
    cyc(1'b1, 32'hB3, 1'b0);
    check_eq("pre_rst_occ", {62'd0, sif.occ}, 64'd1);
    check_eq("pre_rst_pend", {63'd0, dut.rd_pend_r}, 64'd1);
    @(posedge CLK);
    #1;
    RST = 1'b1;
    enq = 1'b0;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    exp_q.delete();
    sif.dout_ready = 1'b1;
    @(negedge CLK);
    check_eq("post_rst_occ", {62'd0, sif.occ}, 64'd0);
    check_eq("post_rst_valid", {63'd0, sif.dout_valid}, 64'd0);
    check_eq("post_rst_pend", {63'd0, dut.rd_pend_r}, 64'd0);
    cyc(1'b1, 32'hC0, 1'b1);
    cyc(1'b1, 32'hC1, 1'b1);
    got = 1'b0;
    for (int k = 0; k < 10; k++) begin
      cyc(1'b0, 32'd0, 1'b1);
      if (sif.dout_valid) begin
        check_eq("post_rst_first", {32'd0, sif.dout}, 64'hC0);
        got = 1'b1;
        break;
      end
    end
    if (!got) check_eq("post_rst_wait", 64'd0, 64'd1);
    repeat (6) cyc(1'b0, 32'd0, 1'b1);
    check_eq("post_rst_drained", 64'(exp_q.size()), 64'd0);

    check_eq("deq_while_empty", 64'(deq_viol), 64'd0);
    check_eq("occ_over_two", 64'(occ_viol), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_bfifo_fwft_stage
